// File: rtl/la_scanreg_pkg.sv
// la_scanreg_pkg: chain length and counter width helpers shared by the scan register files
package la_scanreg_pkg;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  function automatic int chain_len(input int w, input int n);
    return (w + n - 1) / n;
  endfunction
  function automatic int scnt_w(input int w, input int n);
    return clog2(chain_len(w, n) + 1);
  endfunction
endpackage

// File: rtl/la_scanreg_if.sv
// la_scanreg_if: functional/scan bus of the scannable register bank
interface la_scanreg_if import la_scanreg_pkg::*; #(
  parameter int W       = 8,
  parameter int NCHAINS = 1,
  parameter int SW      = scnt_w(W, NCHAINS)
) ();
  logic [W-1:0]       d;
  logic [W-1:0]       q;
  logic               en;
  logic               se;
  logic [NCHAINS-1:0] si;
  logic [NCHAINS-1:0] so;
  logic [SW-1:0]      scnt;
  logic               sdone;
  logic               par;
  modport master(output d, en, se, si, input q, so, scnt, sdone, par);
  modport slave(input d, en, se, si, output q, so, scnt, sdone, par);
endinterface

// File: rtl/la_scanreg_chain.sv
// la_scanreg_chain: one scan chain slice with functional load and optional inversion
module la_scanreg_chain #(
  parameter int             LEN    = 1,
  parameter int             INV    = 0,
  parameter logic [LEN-1:0] RSTVAL = '0
) (
  input  logic           clk,
  input  logic           nreset,
  input  logic [LEN-1:0] d,
  input  logic           en,
  input  logic           se,
  input  logic           si,
  output logic [LEN-1:0] q,
  output logic           so
);
  logic [LEN-1:0] q_d, q_q, src;
  always_comb begin
    src = se ? LEN'({q_q, si}) : d;
    q_d = (se || en) ? ((INV != 0) ? ~src : src) : q_q;
  end
  always_ff @(posedge clk)
    if (!nreset) q_q <= RSTVAL;
    else         q_q <= q_d;
  assign q  = q_q;
  assign so = q_q[LEN-1];
endmodule

// File: rtl/la_scanreg.sv
// la_scanreg: W-bit scannable register bank in NCHAINS chains; LA_SCANREG_PARITY_EN adds a parity flop on par.
module la_scanreg import la_scanreg_pkg::*; #(
  parameter int           W       = 8,
  parameter int           NCHAINS = 1,
  parameter int           INV     = 0,
  parameter logic [W-1:0] RSTVAL  = '0,
  parameter               PROP    = "DEFAULT"
) (
  input logic        clk,
  input logic        nreset,
  la_scanreg_if.slave bus
);
  localparam int L  = chain_len(W, NCHAINS);
  localparam int SW = scnt_w(W, NCHAINS);
  logic [SW-1:0] scnt_d, scnt_q;
  logic          sdone_d, sdone_q;
  for (genvar k = 0; k < NCHAINS; k++) begin : g_chain
    localparam int BASE = k * L;
    localparam int LEN  = (W - BASE < L) ? W - BASE : L;
    la_scanreg_chain #(
      .LEN    (LEN),
      .INV    (INV),
      .RSTVAL (RSTVAL[BASE +: LEN])
    ) u_chain (
      .clk    (clk),
      .nreset (nreset),
      .d      (bus.d[BASE +: LEN]),
      .en     (bus.en),
      .se     (bus.se),
      .si     (bus.si[k]),
      .q      (bus.q[BASE +: LEN]),
      .so     (bus.so[k])
    );
  end
  always_comb begin
    scnt_d  = bus.se ? ((scnt_q == SW'(L)) ? scnt_q : scnt_q + 1'b1) : '0;
    sdone_d = scnt_d == SW'(L);
  end
  always_ff @(posedge clk)
    if (!nreset) begin
      scnt_q  <= '0;
      sdone_q <= 1'b0;
    end else begin
      scnt_q  <= scnt_d;
      sdone_q <= sdone_d;
    end
  assign bus.scnt  = scnt_q;
  assign bus.sdone = sdone_q;
`ifdef LA_SCANREG_PARITY_EN
  localparam logic INV_ODD = (INV != 0) && (W % 2 == 1);
  logic par_d, par_q;
  // a shift drops every chain's top bit and adds every si bit; inverting W bits flips parity when W is odd
  always_comb
    par_d = bus.se ? ((^bus.q) ^ (^bus.so) ^ (^bus.si) ^ INV_ODD) :
            bus.en ? ((^bus.d) ^ INV_ODD) : (^bus.q);
  always_ff @(posedge clk)
    if (!nreset) par_q <= ^RSTVAL;
    else         par_q <= par_d;
  assign bus.par = par_q;
`else
  assign bus.par = 1'b0;
`endif
endmodule

// File: tb/tb_la_scanreg.sv
// tb_la_scanreg: directed checks of reset, load/hold, multi-chain shift, counter and parity
module tb_la_scanreg;
  logic clk = 1'b0;
  logic nreset = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;
`ifdef LA_SCANREG_PARITY_EN
  localparam bit PE = 1'b1;
`else
  localparam bit PE = 1'b0;
`endif
  always #5 clk = ~clk;

  la_scanreg_if #(.W(8), .NCHAINS(1)) ia ();
  la_scanreg_if #(.W(8), .NCHAINS(1)) ib ();
  la_scanreg_if #(.W(8), .NCHAINS(2)) ic ();
  la_scanreg_if #(.W(7), .NCHAINS(2)) id ();

  la_scanreg #(.W(8), .NCHAINS(1), .INV(0), .RSTVAL(8'hA5)) u_a (.clk(clk), .nreset(nreset), .bus(ia.slave));
  la_scanreg #(.W(8), .NCHAINS(1), .INV(1), .RSTVAL(8'h00)) u_b (.clk(clk), .nreset(nreset), .bus(ib.slave));
  la_scanreg #(.W(8), .NCHAINS(2), .INV(0), .RSTVAL(8'h00)) u_c (.clk(clk), .nreset(nreset), .bus(ic.slave));
  la_scanreg #(.W(7), .NCHAINS(2), .INV(0), .RSTVAL(7'h15)) u_d (.clk(clk), .nreset(nreset), .bus(id.slave));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  bit s0 [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
  bit s1 [3] = '{1'b1, 1'b0, 1'b0};

  initial begin
    {ia.d, ia.en, ia.se, ia.si} = '0;
    {ib.d, ib.en, ib.se, ib.si} = '0;
    {ic.d, ic.en, ic.se, ic.si} = '0;
    {id.d, id.en, id.se, id.si} = '0;
    ia.se = 1'b1; ia.en = 1'b1; ia.d = 8'hFF;
    tick;
    chk("rst_q", ia.q, 8'hA5);
    chk("rst_scnt", ia.scnt, 0);
    chk("rst_sdone", ia.sdone, 0);
    chk("rst_par", ia.par, 0);
    chk("rst_d_q", id.q, 7'h15);
    nreset = 1'b1;
    ia.se = 1'b0; ia.d = 8'h07;
    tick;
    chk("par_load_q", ia.q, 8'h07);
    chk("par_load", ia.par, PE ? 1 : 0);
    ia.d = 8'h00;
    tick;
    chk("par_zero", ia.par, 0);
    ia.en = 1'b0; ia.se = 1'b1; ia.si = 1'b1;
    tick;
    chk("par_shift_q", ia.q, 8'h01);
    chk("par_shift", ia.par, PE ? 1 : 0);
    ia.se = 1'b0;
    ib.en = 1'b1; ib.d = 8'h3C;
    tick;
    chk("inv_load", ib.q, 8'hC3);
    ib.en = 1'b0; ib.d = 8'h5A;
    tick;
    chk("inv_hold", ib.q, 8'hC3);
    ic.se = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ic.si = {1'b1, s0[i]};
      chk($sformatf("c_so%0d", i), ic.so, 2'b00);
      tick;
      chk($sformatf("c_scnt%0d", i), ic.scnt, i + 1);
      chk($sformatf("c_sdone%0d", i), ic.sdone, (i == 3) ? 1 : 0);
    end
    chk("c_q", ic.q, 8'hFB);
    chk("c_so_new", ic.so, 2'b11);
    ic.si = 2'b11;
    for (int i = 0; i < 3; i++) tick;
    chk("c_sat_scnt", ic.scnt, 4);
    chk("c_sat_sdone", ic.sdone, 1);
    chk("c_sat_q", ic.q, 8'hFF);
    ic.se = 1'b0;
    tick;
    chk("c_clr_scnt", ic.scnt, 0);
    chk("c_clr_sdone", ic.sdone, 0);
    chk("c_hold_q", ic.q, 8'hFF);
    id.se = 1'b1; id.si = 2'b11;
    tick;
    tick;
    chk("d_scnt2", id.scnt, 2);
    nreset = 1'b0;
    tick;
    chk("d_abort_q", id.q, 7'h15);
    chk("d_abort_scnt", id.scnt, 0);
    chk("d_abort_sdone", id.sdone, 0);
    chk("d_so_rst", id.so, 2'b00);
    nreset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      id.si = {s1[i], 1'b0};
      tick;
    end
    chk("d_q3", id.q, 7'h48);
    chk("d_so3", id.so, 2'b11);
    chk("d_scnt3", id.scnt, 3);
    chk("d_sdone3", id.sdone, 0);
    id.si = 2'b00;
    tick;
    chk("d_sdone4", id.sdone, 1);
    chk("d_scnt4", id.scnt, 4);
    id.se = 1'b0;
    tick;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
